// File: rtl/hash_table_engine.sv
// hash_table_engine
//   Key/value store: TOTAL_INDEX buckets of CHAINING_SIZE slots each.
//   A request is accepted in IDLE. SCAN then examines one slot of the
//   bucket per clock. After the one-cycle op_done pulse the FSM waits in
//   RELEASE until op_en drops.
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   key_in/value_in  request key / insert value (sampled at acceptance)
//   op_sel           00 insert, 01 delete, 10 search, 11 reserved (error)
//   op_en            request valid, held until op_done
//   value_out        search result (0 on a search miss)
//   op_done          one-cycle completion pulse
//   op_error         full bucket / key not found / reserved op
//   collision_count  slots before the match, else valid slots (saturating)
module hash_table_engine #(
    parameter int KEY_WIDTH        = 32,
    parameter int VALUE_WIDTH      = 32,
    parameter int TOTAL_INDEX      = 8,
    parameter int CHAINING_SIZE    = 4,
    parameter     COLLISION_METHOD = "MULTI_STAGE_CHAINING",
    parameter     HASH_ALGORITHM   = "MODULUS",
    // Derived; the floor of 1 keeps the minimum configurations legal.
    parameter int CHAIN_WIDTH      = ($clog2(CHAINING_SIZE-1) < 1) ? 1 : $clog2(CHAINING_SIZE-1),
    parameter int INDEX_WIDTH      = ($clog2(TOTAL_INDEX-1) < 1) ? 1 : $clog2(TOTAL_INDEX-1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic [VALUE_WIDTH-1:0] value_in,
    input  logic [1:0]             op_sel,
    input  logic                   op_en,
    output logic [VALUE_WIDTH-1:0] value_out,
    output logic                   op_done,
    output logic                   op_error,
    output logic [CHAIN_WIDTH-1:0] collision_count
);

    localparam int CNT_W = $clog2(CHAINING_SIZE + 1);
    localparam logic [CHAIN_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CHAIN_WIDTH-1:0] LAST_SLOT = CHAIN_WIDTH'(CHAINING_SIZE - 1);

    localparam logic [1:0] OP_INS  = 2'b00;
    localparam logic [1:0] OP_DEL  = 2'b01;
    localparam logic [1:0] OP_SRCH = 2'b10;

    typedef enum logic [1:0] {IDLE, SCAN, RELEASE} state_t;

    state_t state, nxt_state;

    // Table storage; only the valid bits need reset.
    logic                   tbl_vld [TOTAL_INDEX][CHAINING_SIZE];
    logic [KEY_WIDTH-1:0]   tbl_key [TOTAL_INDEX][CHAINING_SIZE];
    logic [VALUE_WIDTH-1:0] tbl_val [TOTAL_INDEX][CHAINING_SIZE];

    // Request context latched at acceptance
    logic [KEY_WIDTH-1:0]   lat_key;
    logic [VALUE_WIDTH-1:0] lat_val;
    logic [1:0]             lat_op;
    logic [INDEX_WIDTH-1:0] bucket;
    logic [CHAIN_WIDTH-1:0] ptr;
    logic                   free_found;
    logic [CHAIN_WIDTH-1:0] free_idx;

    // Slot under examination
    logic cur_vld, hit, last;
    assign cur_vld = tbl_vld[bucket][ptr];
    assign hit     = cur_vld && (tbl_key[bucket][ptr] == lat_key);
    assign last    = (ptr == LAST_SLOT);

    // Valid-slot population of the active bucket, saturated to the output width
    logic [CNT_W-1:0]       vld_cnt;
    logic [CHAIN_WIDTH-1:0] vld_cnt_sat;
    always_comb begin
        vld_cnt = '0;
        for (int i = 0; i < CHAINING_SIZE; i++)
            vld_cnt = vld_cnt + CNT_W'(tbl_vld[bucket][i]);
        vld_cnt_sat = (vld_cnt > CNT_W'(CNT_MAX)) ? CNT_MAX : vld_cnt[CHAIN_WIDTH-1:0];
    end

    // Next-state and completion decode
    logic                   done, err, vout_ld, wr, clr;
    logic [CHAIN_WIDTH-1:0] coll, wr_slot;
    logic [VALUE_WIDTH-1:0] vout_n;

    always_comb begin
        nxt_state = state;
        done      = 1'b0;
        err       = 1'b0;
        vout_ld   = 1'b0;
        vout_n    = '0;
        wr        = 1'b0;
        clr       = 1'b0;
        wr_slot   = ptr;
        coll      = '0;
        case (state)
            IDLE: if (op_en) nxt_state = SCAN;
            SCAN: begin
                case (lat_op)
                    OP_INS: begin
                        if (hit) begin
                            // Existing key: overwrite in place
                            done = 1'b1;
                            wr   = 1'b1;
                            coll = ptr;
                        end else if (last) begin
                            done = 1'b1;
                            coll = vld_cnt_sat;
                            if (free_found || !cur_vld) begin
                                wr      = 1'b1;
                                wr_slot = free_found ? free_idx : ptr;
                            end else begin
                                err = 1'b1;
                            end
                        end
                    end
                    OP_DEL: begin
                        if (hit) begin
                            done = 1'b1;
                            clr  = 1'b1;
                            coll = ptr;
                        end else if (last) begin
                            done = 1'b1;
                            err  = 1'b1;
                            coll = vld_cnt_sat;
                        end
                    end
                    OP_SRCH: begin
                        if (hit) begin
                            done    = 1'b1;
                            vout_ld = 1'b1;
                            vout_n  = tbl_val[bucket][ptr];
                            coll    = ptr;
                        end else if (last) begin
                            done    = 1'b1;
                            err     = 1'b1;
                            vout_ld = 1'b1;
                            coll    = vld_cnt_sat;
                        end
                    end
                    default: begin
                        // Reserved opcode completes on the first scan edge
                        done = 1'b1;
                        err  = 1'b1;
                    end
                endcase
                if (done) nxt_state = RELEASE;
            end
            RELEASE: if (!op_en) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            lat_key         <= '0;
            lat_val         <= '0;
            lat_op          <= '0;
            bucket          <= '0;
            ptr             <= '0;
            free_found      <= 1'b0;
            free_idx        <= '0;
            op_done         <= 1'b0;
            op_error        <= 1'b0;
            collision_count <= '0;
            value_out       <= '0;
        end else begin
            state   <= nxt_state;
            op_done <= done;
            if (state == IDLE && op_en) begin
                lat_key    <= key_in;
                lat_val    <= value_in;
                lat_op     <= op_sel;
                // Power-of-two bucket count: modulus is the low key bits
                bucket     <= key_in[INDEX_WIDTH-1:0];
                ptr        <= '0;
                free_found <= 1'b0;
            end
            if (state == SCAN && !done) begin
                ptr <= ptr + 1'b1;
                // Remember the lowest hole in case the key is not present
                if (!cur_vld && !free_found) begin
                    free_found <= 1'b1;
                    free_idx   <= ptr;
                end
            end
            if (done) begin
                op_error        <= err;
                collision_count <= coll;
                if (vout_ld) value_out <= vout_n;
            end
        end
    end

    // Valid bits: cleared by reset, set on insert, cleared on delete
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < TOTAL_INDEX; b++)
                for (int s = 0; s < CHAINING_SIZE; s++)
                    tbl_vld[b][s] <= 1'b0;
        end else begin
            if (wr)  tbl_vld[bucket][wr_slot] <= 1'b1;
            if (clr) tbl_vld[bucket][ptr]     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            tbl_key[bucket][wr_slot] <= lat_key;
            tbl_val[bucket][wr_slot] <= lat_val;
        end
    end

endmodule

// File: tb/tb_hash_table_engine.sv
// Directed bench for hash_table_engine: hand-computed results for insert,
// delete, search, full bucket, update, reserved op, handshake and reset.
module tb_hash_table_engine;

    logic        clk;
    logic        rst;
    logic [31:0] key_in, value_in, value_out;
    logic [1:0]  op_sel;
    logic        op_en, op_done, op_error;
    logic [1:0]  collision_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] r_val;
    logic        r_err;
    logic [1:0]  r_coll;
    int          r_lat;

    localparam logic [1:0] INS = 2'b00, DEL = 2'b01, SRCH = 2'b10, RSV = 2'b11;

    hash_table_engine dut (
        .clk(clk), .rst(rst), .key_in(key_in), .value_in(value_in),
        .op_sel(op_sel), .op_en(op_en), .value_out(value_out),
        .op_done(op_done), .op_error(op_error), .collision_count(collision_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge; capture results at op_done.
    // op_en stays high for 'hold' cycles after op_done, during which no
    // further completion may appear.
    task automatic do_op(input logic [1:0] op, input logic [31:0] k,
                         input logic [31:0] v, input int hold);
        bit seen = 0;
        op_sel = op; key_in = k; value_in = v; op_en = 1'b1;
        @(posedge clk);              // acceptance edge
        r_lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (op_done) begin
                seen = 1; r_lat = i;
                r_val = value_out; r_err = op_error; r_coll = collision_count;
                break;
            end
        end
        chk("op_timeout", 32'(seen), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("done_pulse", 32'(op_done), 32'd0);
        end
        @(negedge clk); op_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; op_en = 1'b0; op_sel = 2'b00; key_in = '0; value_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", 32'(op_done), 0);
        chk("rst_err",  32'(op_error), 0);
        chk("rst_val",  value_out, 0);
        chk("rst_coll", 32'(collision_count), 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic insert / search
        do_op(INS, 1, 2, 1);   chk("ins1_err", 32'(r_err), 0); chk("ins1_lat", r_lat, 4);
        chk("ins1_coll", 32'(r_coll), 0);
        do_op(SRCH, 1, 0, 1);  chk("s1_err", 32'(r_err), 0); chk("s1_val", r_val, 2);
        chk("s1_lat", r_lat, 1); chk("s1_coll", 32'(r_coll), 0);

        // Delete and miss
        do_op(INS, 3, 2, 1);   chk("ins3_err", 32'(r_err), 0);
        do_op(DEL, 1, 0, 1);   chk("del1_err", 32'(r_err), 0); chk("del1_lat", r_lat, 1);
        do_op(SRCH, 1, 0, 1);  chk("s1m_err", 32'(r_err), 1); chk("s1m_val", r_val, 0);
        chk("s1m_lat", r_lat, 4); chk("s1m_coll", 32'(r_coll), 0);
        do_op(SRCH, 3, 0, 1);  chk("s3_err", 32'(r_err), 0); chk("s3_val", r_val, 2);

        // Fill bucket 0, then overflow
        do_op(INS, 0, 10, 1);  chk("ins0_err", 32'(r_err), 0);
        do_op(INS, 8, 11, 1);  chk("ins8_err", 32'(r_err), 0); chk("ins8_coll", 32'(r_coll), 1);
        do_op(INS, 16, 12, 1); chk("ins16_err", 32'(r_err), 0);
        do_op(INS, 24, 13, 1); chk("ins24_err", 32'(r_err), 0); chk("ins24_coll", 32'(r_coll), 3);
        do_op(INS, 32, 9, 1);  chk("ins32_err", 32'(r_err), 1); chk("ins32_coll", 32'(r_coll), 3);
        chk("ins32_lat", r_lat, 4);
        do_op(SRCH, 32, 0, 1); chk("s32_err", 32'(r_err), 1); chk("s32_coll", 32'(r_coll), 3);

        // Update existing key in full bucket
        do_op(INS, 8, 7, 1);   chk("upd8_err", 32'(r_err), 0); chk("upd8_lat", r_lat, 2);
        chk("upd8_coll", 32'(r_coll), 1);
        do_op(SRCH, 8, 0, 1);  chk("s8_val", r_val, 7); chk("s8_coll", 32'(r_coll), 1);

        // Delete miss on empty bucket, reserved op; table unchanged
        do_op(DEL, 5, 0, 1);   chk("del5_err", 32'(r_err), 1); chk("del5_lat", r_lat, 4);
        chk("del5_coll", 32'(r_coll), 0);
        do_op(RSV, 3, 0, 1);   chk("rsv_err", 32'(r_err), 1); chk("rsv_lat", r_lat, 1);
        do_op(SRCH, 3, 0, 1);  chk("s3b_err", 32'(r_err), 0); chk("s3b_val", r_val, 2);

        // Hole left by delete is reused by a later insert
        do_op(DEL, 8, 0, 1);   chk("del8_err", 32'(r_err), 0); chk("del8_coll", 32'(r_coll), 1);
        do_op(INS, 40, 20, 1); chk("ins40_err", 32'(r_err), 0); chk("ins40_coll", 32'(r_coll), 3);
        do_op(SRCH, 40, 0, 1); chk("s40_val", r_val, 20); chk("s40_coll", 32'(r_coll), 1);
        chk("s40_lat", r_lat, 2);

        // Handshake: op_en held 3 cycles past op_done
        do_op(INS, 5, 55, 3);  chk("ins5_err", 32'(r_err), 0);
        do_op(SRCH, 5, 0, 1);  chk("s5_val", r_val, 55);
        do_op(SRCH, 16, 0, 1); chk("s16_val", r_val, 12); chk("s16_coll", 32'(r_coll), 2);

        // Reset in the middle of a scan
        op_sel = SRCH; key_in = 32; op_en = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        chk("mrst_done", 32'(op_done), 0);
        chk("mrst_err",  32'(op_error), 0);
        chk("mrst_val",  value_out, 0);
        chk("mrst_coll", 32'(collision_count), 0);
        op_en = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        do_op(SRCH, 3, 0, 1);  chk("s3r_err", 32'(r_err), 1); chk("s3r_val", r_val, 0);
        do_op(SRCH, 16, 0, 1); chk("s16r_err", 32'(r_err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
